// File: rtl/cellrv32_cpu_cp_fpu16_i2h.sv
// cellrv32_cpu_cp_fpu16_i2h
// Sequential 32-bit integer to IEEE-754 binary16 converter (FCVT.H.W / FCVT.H.WU).
// Optional macro CELLRV32_FPU16_I2H_FAST_NORM_EN enables 4-bit normalization steps.
module cellrv32_cpu_cp_fpu16_i2h #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      rmode_i,
    input  logic            funct_i,
    input  logic [XLEN-1:0] int_i,
    output logic [15:0]     result_o,
    output logic [4:0]      flags_o,
    output logic            done_o
);

    // exception flag bit positions inside flags_o
    localparam int FP_EXC_NV_C = 0;
    localparam int FP_EXC_DZ_C = 1;
    localparam int FP_EXC_OF_C = 2;
    localparam int FP_EXC_UF_C = 3;
    localparam int FP_EXC_NX_C = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPARE,
        S_NORMALIZE,
        S_ROUND,
        S_FINALIZE
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;

    logic [XLEN-1:0] r_int;
    logic            r_funct;
    logic [2:0]      r_rmode;
    logic            r_sign;
    logic            r_zero;
    logic [31:0]     r_mag;
    logic [4:0]      r_cnt;
    logic [5:0]      r_exp;
    logic [9:0]      r_man;
    logic            r_inexact;
    logic [15:0]     r_result;
    logic [4:0]      r_flags;
    logic            r_done;

    logic            w_sign;
    logic [31:0]     w_magInit;
    logic            w_g;
    logic            w_r;
    logic            w_s;
    logic [9:0]      w_manRaw;
    logic [5:0]      w_expRaw;
    logic            w_roundUp;
    logic [10:0]     w_manSum;
    logic            w_carry;
    logic [15:0]     w_result;
    logic [4:0]      w_flags;

    // sign and magnitude of the latched operand; the most negative value keeps magnitude 0x80000000
    always_comb begin
        w_sign    = ~r_funct & r_int[31];
        w_magInit = w_sign ? (32'd0 - r_int) : r_int;
    end

    // guard/round/sticky extraction and rounding decision for the normalized magnitude
    always_comb begin
        w_g      = r_mag[20];
        w_r      = r_mag[19];
        w_s      = |r_mag[18:0];
        w_manRaw = r_mag[30:21];
        w_expRaw = {1'b0, r_cnt} + 6'd15;
        w_roundUp = 1'b0;
        case (r_rmode)
            3'b000:  w_roundUp = w_g & (w_r | w_s | w_manRaw[0]);
            3'b010:  w_roundUp = r_sign & (w_g | w_r | w_s);
            3'b011:  w_roundUp = ~r_sign & (w_g | w_r | w_s);
            3'b100:  w_roundUp = w_g;
            default: w_roundUp = 1'b0;
        endcase
        // incrementing {1, man} carries out exactly when man is all ones
        w_manSum = {1'b0, w_manRaw} + {10'd0, w_roundUp};
        w_carry  = w_manSum[10];
    end

    // final packing: zero, overflow saturation by rounding direction, or normal value
    always_comb begin
        w_result = {r_sign, r_exp[4:0], r_man};
        w_flags  = 5'd0;
        if (r_zero) begin
            w_result = 16'h0000;
        end else if (r_exp >= 6'd31) begin
            w_flags[FP_EXC_OF_C] = 1'b1;
            w_flags[FP_EXC_NX_C] = 1'b1;
            case (r_rmode)
                3'b000, 3'b100: w_result = {r_sign, 5'h1F, 10'h000};
                3'b010:  w_result = r_sign ? 16'hFC00 : 16'h7BFF;
                3'b011:  w_result = r_sign ? 16'hFBFF : 16'h7C00;
                default: w_result = {r_sign, 5'h1E, 10'h3FF};
            endcase
        end else begin
            w_flags[FP_EXC_NX_C] = r_inexact;
        end
        w_flags[FP_EXC_NV_C] = 1'b0;
        w_flags[FP_EXC_DZ_C] = 1'b0;
        w_flags[FP_EXC_UF_C] = 1'b0;
    end

    // next-state logic of the conversion sequencer
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:      if (start_i) w_stateNext = S_PREPARE;
            S_PREPARE:   w_stateNext = (w_magInit == 32'd0) ? S_FINALIZE : S_NORMALIZE;
            S_NORMALIZE: if (r_mag[31]) w_stateNext = S_ROUND;
            S_ROUND:     w_stateNext = S_FINALIZE;
            S_FINALIZE:  w_stateNext = S_IDLE;
            default:     w_stateNext = S_IDLE;
        endcase
    end

    // state register and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_int     <= '0;
            r_funct   <= 1'b0;
            r_rmode   <= 3'd0;
            r_sign    <= 1'b0;
            r_zero    <= 1'b0;
            r_mag     <= 32'd0;
            r_cnt     <= 5'd0;
            r_exp     <= 6'd0;
            r_man     <= 10'd0;
            r_inexact <= 1'b0;
            r_result  <= 16'h0000;
            r_flags   <= 5'd0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_done  <= (r_state == S_FINALIZE);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_int   <= int_i;
                        r_funct <= funct_i;
                        r_rmode <= rmode_i;
                    end
                end
                S_PREPARE: begin
                    r_sign <= w_sign;
                    r_mag  <= w_magInit;
                    r_cnt  <= 5'd31;
                    r_zero <= (w_magInit == 32'd0);
                end
                S_NORMALIZE: begin
                    if (!r_mag[31]) begin
`ifdef CELLRV32_FPU16_I2H_FAST_NORM_EN
                        if (r_mag[31:28] == 4'd0) begin
                            r_mag <= {r_mag[27:0], 4'd0};
                            r_cnt <= r_cnt - 5'd4;
                        end else begin
                            r_mag <= {r_mag[30:0], 1'b0};
                            r_cnt <= r_cnt - 5'd1;
                        end
`else
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_cnt <= r_cnt - 5'd1;
`endif
                    end
                end
                S_ROUND: begin
                    r_man     <= w_carry ? 10'd0 : w_manSum[9:0];
                    r_exp     <= w_expRaw + {5'd0, w_carry};
                    r_inexact <= w_g | w_r | w_s;
                end
                S_FINALIZE: begin
                    r_result <= w_result;
                    r_flags  <= w_flags;
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign flags_o  = r_flags;
    assign done_o   = r_done;

endmodule
